pipe_hazard_ctrl: RTL

Hazard and sequencing controller for the five-stage pipelined ARM core (IF, DEC, EX, MEM, WB).

- Detects load-use hazards between the instruction in DEC and a load in EX. Stalls IF/DEC and injects one EX bubble.
- Squashes the wrong-path fetch when DEC resolves a taken branch.
- Provides a halt sequence that drains the pipeline before freezing the PC.

It drives the write-enable, flush and bubble controls of the IF/DEC and DEC/EX pipeline registers and the PC register.

---
 rtl/pipe_hazard_ctrl_if.sv | 35 +++
 rtl/pipe_hazard_ctrl.sv | 123 ++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline hazard controller bus: DEC/EX hazard inputs, halt request and the
// pipeline-register control outputs.
interface pipe_hazard_ctrl_if;
  logic [4:0]  dec_rn;
  logic [4:0]  dec_rm;
  logic        dec_uses_rn;
  logic        dec_uses_rm;
  logic        dec_br_taken;
  logic [4:0]  ex_aw;
  logic        ex_reg_write;
  logic        ex_mem_to_reg;
  logic        halt_req;
  logic        pc_wr_en;
  logic        ifdec_wr_en;
  logic        ifdec_flush;
  logic        decex_bubble;
  logic        halted;
  logic [1:0]  state;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  modport master (
    output dec_rn, dec_rm, dec_uses_rn, dec_uses_rm, dec_br_taken,
           ex_aw, ex_reg_write, ex_mem_to_reg, halt_req,
    input  pc_wr_en, ifdec_wr_en, ifdec_flush, decex_bubble, halted,
           state, stall_cnt, flush_cnt
  );

  modport slave (
    input  dec_rn, dec_rm, dec_uses_rn, dec_uses_rm, dec_br_taken,
           ex_aw, ex_reg_write, ex_mem_to_reg, halt_req,
    output pc_wr_en, ifdec_wr_en, ifdec_flush, decex_bubble, halted,
           state, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Load-use stall, branch squash and halt-drain sequencing for the 5-stage core.
// Optional perf counters (stall_cnt/flush_cnt) enabled by HAZARD_PERF_CNT_EN.
module pipe_hazard_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 4
) (
  input logic               clk,
  input logic               reset,
  pipe_hazard_ctrl_if.slave hif
);
  localparam int unsigned DRAIN_W = 4;
  localparam int unsigned CNT_W   = 16;
  localparam logic [4:0]  XZR     = 5'd31;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LDSTALL = 2'd1,
    DRAIN   = 2'd2,
    HALT    = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic               hazard;
  logic               pc_wr_en, ifdec_wr_en, ifdec_flush, decex_bubble, halted;

  assign hazard = hif.ex_reg_write && hif.ex_mem_to_reg && (hif.ex_aw != XZR) &&
                  ((hif.dec_uses_rn && (hif.dec_rn == hif.ex_aw)) ||
                   (hif.dec_uses_rm && (hif.dec_rm == hif.ex_aw)));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= RUN;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  // Next state and pipeline controls; reset low overrides to a frozen, flushed pipe.
  always_comb begin
    state_d      = state_q;
    drain_d      = drain_q;
    pc_wr_en     = 1'b1;
    ifdec_wr_en  = 1'b1;
    ifdec_flush  = 1'b0;
    decex_bubble = 1'b0;
    halted       = 1'b0;
    case (state_q)
      RUN: begin
        if (hazard) begin
          pc_wr_en     = 1'b0;
          ifdec_wr_en  = 1'b0;
          decex_bubble = 1'b1;
          state_d      = LDSTALL;
        end else if (hif.dec_br_taken) begin
          ifdec_flush = 1'b1;
        end else if (hif.halt_req) begin
          pc_wr_en    = 1'b0;
          ifdec_flush = 1'b1;
          drain_d     = DRAIN_W'(DRAIN_CYCLES - 1);
          state_d     = DRAIN;
        end
      end
      LDSTALL: state_d = RUN;
      DRAIN: begin
        pc_wr_en     = 1'b0;
        ifdec_wr_en  = 1'b0;
        ifdec_flush  = 1'b1;
        decex_bubble = 1'b1;
        if (drain_q == '0) state_d = HALT;
        else               drain_d = drain_q - DRAIN_W'(1);
      end
      HALT: begin
        pc_wr_en     = 1'b0;
        ifdec_wr_en  = 1'b0;
        ifdec_flush  = 1'b1;
        decex_bubble = 1'b1;
        halted       = 1'b1;
      end
      default: state_d = RUN;
    endcase
    if (!reset) begin
      pc_wr_en     = 1'b0;
      ifdec_wr_en  = 1'b0;
      ifdec_flush  = 1'b1;
      decex_bubble = 1'b1;
      halted       = 1'b0;
    end
  end

  assign hif.pc_wr_en     = pc_wr_en;
  assign hif.ifdec_wr_en  = ifdec_wr_en;
  assign hif.ifdec_flush  = ifdec_flush;
  assign hif.decex_bubble = decex_bubble;
  assign hif.halted       = halted;
  assign hif.state        = state_q;

`ifdef HAZARD_PERF_CNT_EN
  logic             stall_hit, flush_hit;
  logic [CNT_W-1:0] stall_q, flush_q;

  // Only RUN-state stalls and branch squashes count; drain/halt flushes do not.
  assign stall_hit = (state_q == RUN) && hazard;
  assign flush_hit = (state_q == RUN) && !hazard && hif.dec_br_taken;

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall_hit && (stall_q != '1)) stall_q <= stall_q + CNT_W'(1);
      if (flush_hit && (flush_q != '1)) flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign hif.stall_cnt = stall_q;
  assign hif.flush_cnt = flush_q;
`else
  assign hif.stall_cnt = '0;
  assign hif.flush_cnt = '0;
`endif
endmodule
